byte_swap_arbiter: RTL and testbench

//   Shares one registered byte-reversal datapath between two streaming requesters.

---
 rtl/byte_swap_arbiter_if.sv | 42 ++++
 rtl/byte_swap_arbiter.sv | 133 +++++++++++++
 tb/tb_byte_swap_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/byte_swap_arbiter_if.sv
// Stream bundle for byte_swap_arbiter: two requester ports in, one tagged output stream.
// master drives the requesters and out_ready; slave is the arbiter side.
interface byte_swap_arbiter_if #(
  parameter int BYTES = 4
);
  localparam int W = 8 * BYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic         req0_swap;
  logic         req0_last;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_data;
  logic         req1_swap;
  logic         req1_last;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;

  modport master (
    output req0_valid, req0_data, req0_swap, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_swap, req1_last,
    input  req1_ready,
    input  out_valid, out_data, out_src,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_swap, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_swap, req1_last,
    output req1_ready,
    output out_valid, out_data, out_src,
    input  out_ready
  );
endinterface

// File: rtl/byte_swap_arbiter.sv
// Two-requester burst-level round-robin arbiter feeding one registered,
// optionally byte-reversing datapath with a 1-entry output stage.
//
// state | meaning
// IDLE  | no burst in progress; grant by validity, rr breaks ties
// LOCK0 | requester 0 owns the datapath until its last beat is accepted
// LOCK1 | requester 1 owns the datapath until its last beat is accepted
module byte_swap_arbiter #(
  parameter int BYTES = 4
) (
  input logic                 clock,
  input logic                 resetn,
  byte_swap_arbiter_if.slave  bus
);
  localparam int W = 8 * BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         rr_q, rr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_src_q, out_src_d;

  logic         load;
  logic         grant_valid;
  logic         grant;
  logic         ready0, ready1;
  logic         xfer;
  logic [W-1:0] sel_data;
  logic         sel_swap;
  logic         sel_last;
  logic [W-1:0] swapped;

  // Output register accepts a new beat when empty or draining this cycle.
  assign load = !out_valid_q | bus.out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant_valid = 1'b1;
          grant       = rr_q;
        end else if (bus.req0_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (bus.req1_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
      end
      LOCK0: begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end
      LOCK1: begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
      default: begin
        grant_valid = 1'b0;
        grant       = rr_q;
      end
    endcase
  end

  // resetn gates ready so nothing is accepted while the flops are held clear.
  assign ready0 = resetn & load & grant_valid & !grant;
  assign ready1 = resetn & load & grant_valid & grant;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  assign sel_data = grant ? bus.req1_data : bus.req0_data;
  assign sel_swap = grant ? bus.req1_swap : bus.req0_swap;
  assign sel_last = grant ? bus.req1_last : bus.req0_last;
  assign xfer     = grant ? (bus.req1_valid & ready1) : (bus.req0_valid & ready0);

  always_comb begin
    swapped = '0;
    for (int i = 0; i < BYTES; i++) begin
      swapped[8*i +: 8] = sel_data[8*(BYTES-1-i) +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_src_d   = grant;
      out_data_d  = sel_swap ? swapped : sel_data;
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = ~grant;
      end else begin
        state_d = grant ? LOCK1 : LOCK0;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_byte_swap_arbiter.sv
// Bench for byte_swap_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a burst-level reference model.
module tb_byte_swap_arbiter;
  localparam int BYTES = 6;
  localparam int W     = 8 * BYTES;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  byte_swap_arbiter_if #(.BYTES(BYTES)) bus ();
  byte_swap_arbiter #(.BYTES(BYTES)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference model: owner of the datapath (-1 none), round-robin pointer, output register.
  int           m_owner;
  bit           m_rr;
  bit           m_ov;
  bit           m_os;
  logic [W-1:0] m_od;

  typedef struct {
    logic [W-1:0] d;
    bit           s;
  } beat_t;
  beat_t sb[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(logic [W-1:0] d);
    logic [W-1:0] r;
    logic [W-1:0] mask;
    r    = '0;
    mask = W'(255);
    for (int i = 0; i < BYTES; i++) r = (r << 8) | ((d >> (8 * i)) & mask);
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 1'b0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_os    = 1'b0;
    sb.delete();
  endtask

  task automatic drive(bit v0, logic [W-1:0] d0, bit s0, bit l0,
                       bit v1, logic [W-1:0] d1, bit s1, bit l1, bit ordy);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_swap = s0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_swap = s1; bus.req1_last = l1;
    bus.out_ready  = ordy;
  endtask

  // One clock: check readys and output handshakes before the edge, outputs after it.
  task automatic step();
    int           g;
    bit           ld, e0, e1, xf, ordy, lst, sw;
    logic [W-1:0] dat;
    beat_t        b;
    #1;
    ordy = bus.out_ready;
    ld   = !m_ov || ordy;
    if (m_owner >= 0)                        g = m_owner;
    else if (bus.req0_valid && bus.req1_valid) g = m_rr ? 1 : 0;
    else if (bus.req0_valid)                 g = 0;
    else if (bus.req1_valid)                 g = 1;
    else                                     g = -1;
    e0 = resetn && ld && (g == 0);
    e1 = resetn && ld && (g == 1);
    check("req0_ready", bus.req0_ready, e0);
    check("req1_ready", bus.req1_ready, e1);

    if (bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("sb_data", bus.out_data, b.d);
        check("sb_src", bus.out_src, b.s);
      end
    end
    if (bus.req0_valid && bus.req0_ready)
      sb.push_back('{d: bus.req0_swap ? rev(bus.req0_data) : bus.req0_data, s: 1'b0});
    if (bus.req1_valid && bus.req1_ready)
      sb.push_back('{d: bus.req1_swap ? rev(bus.req1_data) : bus.req1_data, s: 1'b1});

    xf  = (g == 0 && bus.req0_valid && e0) || (g == 1 && bus.req1_valid && e1);
    dat = (g == 1) ? bus.req1_data : bus.req0_data;
    sw  = (g == 1) ? bus.req1_swap : bus.req0_swap;
    lst = (g == 1) ? bus.req1_last : bus.req0_last;

    @(posedge clock);
    if (xf) begin
      m_ov = 1'b1;
      m_os = (g == 1);
      m_od = sw ? rev(dat) : dat;
      if (lst) begin
        m_owner = -1;
        m_rr    = (g == 0);
      end else begin
        m_owner = g;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", bus.out_valid, m_ov);
    check("out_data", bus.out_data, m_od);
    check("out_src", bus.out_src, m_os);
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  int exp3[4] = '{0, 1, 0, 1};

  initial begin
    model_reset();
    drive(0, '0, 0, 0, 0, '0, 0, 0, 0);
    #1;
    do_reset();

    // Single beat with and without reversal.
    drive(1, 48'haabbccddeeff, 1, 1, 0, '0, 0, 0, 1);
    step();
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 48'hffeeddccbbaa);
    check("t1_src", bus.out_src, 0);
    drive(1, 48'haabbccddeeff, 0, 1, 0, '0, 0, 0, 1);
    step();
    check("t2_data", bus.out_data, 48'haabbccddeeff);

    // Single-beat bursts from both requesters alternate.
    do_reset();
    drive(1, 48'h111111111111, 0, 1, 1, 48'h222222222222, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_src_seq", bus.out_src, exp3[i]);
    end

    // A 3-beat burst from req0 locks out req1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, W'(48'h0a0b0c0d0e00 + i), i[0], (i == 2), 1, 48'h010203040506, 0, 1, 1);
      #1;
      check("t4_req1_locked", bus.req1_ready, 0);
      step();
      check("t4_src_burst", bus.out_src, 0);
    end
    drive(0, '0, 0, 0, 1, 48'h010203040506, 0, 1, 1);
    step();
    check("t4_src_after", bus.out_src, 1);
    check("t4_data_after", bus.out_data, 48'h010203040506);

    // Backpressure holds output and blocks both requesters.
    drive(1, 48'h5a5a00ff1234, 1, 1, 1, 48'h778899aabbcc, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_req0_ready", bus.req0_ready, 0);
      check("t5_req1_ready", bus.req1_ready, 0);
      step();
      check("t5_hold_data", bus.out_data, 48'h010203040506);
      check("t5_hold_src", bus.out_src, 1);
    end
    drive(1, 48'h5a5a00ff1234, 1, 1, 0, '0, 0, 0, 1);
    step();
    check("t5_release_data", bus.out_data, 48'h3412ff005a5a);
    drive(0, '0, 0, 0, 0, '0, 0, 0, 1);
    step();
    check("t5_drained", bus.out_valid, 0);

    // Reset in the middle of a req1 burst releases the lock and rr.
    do_reset();
    drive(0, '0, 0, 0, 1, 48'hdeadbeef0001, 0, 0, 1);
    step();
    check("t6_first_beat", bus.out_src, 1);
    do_reset();
    drive(1, 48'h000000000abc, 0, 1, 1, 48'hdeadbeef0002, 0, 1, 1);
    #1;
    check("t6_req0_granted", bus.req0_ready, 1);
    check("t6_req1_blocked", bus.req1_ready, 0);
    step();
    check("t6_src", bus.out_src, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      drive($urandom_range(0, 3) != 0, W'({$urandom(), $urandom()}), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, W'({$urandom(), $urandom()}), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
      step();
    end

    drive(0, '0, 0, 0, 0, '0, 0, 0, 1);
    step();
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
